axis_frame_packer: RTL and testbench
====================================

# axis_frame_packer

Output framing stage placed directly downstream of `imageProcessTop`. It accepts the filtered 8-bit pixel stream, buffers it in a small first-word-fall-through FIFO, and presents it as an AXI-Stream master with TLAST on the final pixel of every IMG_WIDTH×IMG_HEIGHT frame. It also reports frame completion and pixel-drop overflow to the host.

## Interface
Parameters:
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame
- DATA_WIDTH, 8, pixel width
- FIFO_DEPTH, 16, FIFO entries; power of 2, ≥2

Ports:
- axi_clk  in  1  single clock; all logic on the rising edge
- axi_reset  in  1  asynchronous, active-high reset
- i_data_valid  in  1  upstream pixel valid
- i_data  in  DATA_WIDTH  upstream pixel
- o_data_ready  out  1  FIFO can accept a pixel; informational to upstream
- o_data_valid  out  1  AXIS TVALID
- o_data  out  DATA_WIDTH  AXIS TDATA
- o_data_last  out  1  AXIS TLAST; final pixel of the frame
- i_data_ready  in  1  AXIS TREADY from the sink
- o_frame_done  out  1  one-cycle pulse after the TLAST beat is accepted
- o_frame_count  out  16  number of completed frames; wraps modulo 2^16
- o_overflow  out  1  sticky flag: at least one pixel was dropped

## Operation
- Write: pixel enters the FIFO when i_data_valid=1 and (not full, or a read occurs in the same cycle).
- Overflow: i_data_valid=1, FIFO full, no read in the same cycle:
  - pixel dropped;
  - o_overflow set; it stays set until axi_reset.
- Read/handshake:
  - o_data_valid = FIFO not empty; o_data = head entry.
  - A beat transfers when o_data_valid & i_data_ready.
  - o_data and o_data_valid hold stable while i_data_ready=0.
- Pixel counter: counts transferred beats, 0 … IMG_WIDTH*IMG_HEIGHT-1.
  - o_data_last = o_data_valid & (count == IMG_WIDTH*IMG_HEIGHT-1).
  - On the TLAST transfer, the counter wraps to 0 and o_frame_count increments.
  - Dropped pixels are not counted.
- Output state machine, two states:
  - STREAM → DONE on the TLAST transfer.
  - DONE lasts exactly one cycle, then returns to STREAM.
  - o_frame_done=1 only in DONE.
  - Reads continue during DONE, with count starting from 0.
- Simultaneous write and read on an empty FIFO: write only; no read, because o_data_valid was 0.
- Simultaneous write and read on a full FIFO: both happen; occupancy unchanged; no overflow.
- o_data_ready = ~full & ~axi_reset.

## Timing
- Reset (asynchronous assert, synchronous to the next edge on release):
  - FIFO empty;
  - o_data_valid=0, o_data=0, o_data_last=0;
  - o_frame_done=0, o_frame_count=0, o_overflow=0;
  - o_data_ready=0 while reset is asserted, 1 afterwards.
- Reset mid-frame discards FIFO contents and the pixel count; the next accepted pixel is pixel 0 of a new frame.
- Latency: a pixel written at edge N drives o_data_valid=1 in the cycle after edge N (1 cycle). It transfers at edge N+1 if i_data_ready=1.
- Throughput: 1 pixel/cycle sustained with i_data_ready held high.
- o_frame_done pulses in the cycle after the TLAST handshake edge. o_frame_count is updated at that same edge.
- o_overflow rises in the cycle after the dropping edge.

## Configuration
- Macro `TUSER_SOF_EN`.
- Defined:
  - adds output port o_data_user (1 bit, AXIS TUSER);
  - o_data_user = o_data_valid & (count == 0), i.e. start-of-frame on the first pixel of each frame;
  - reset value 0.
- Undefined: port absent; all other behaviour identical.

## Test plan
Parameters for all tests: IMG_WIDTH=4, IMG_HEIGHT=2, FIFO_DEPTH=4.
- Streaming: 16 consecutive pixels 0x00..0x0F with i_data_ready=1.
  - Outputs in order with 1-cycle latency.
  - o_data_last on values 0x07 and 0x0F.
  - o_frame_done pulses twice; o_frame_count ends at 2; o_overflow=0.
- Backpressure: 4 pixels 0xA0..0xA3 written with i_data_ready=0.
  - o_data_ready=0 after the 4th pixel; o_data holds 0xA0.
  - Raising ready drains 0xA0..0xA3 in order, 1 per cycle.
- Overflow: full FIFO, ready=0, a 5th pixel 0xFF presented.
  - 0xFF never appears on the output; o_overflow=1 the next cycle and remains 1.
  - Frame count/TLAST position excludes the dropped pixel.
- Full with simultaneous read/write: full FIFO, ready=1, continuous writes.
  - No overflow; occupancy stays 4; output order preserved.
- Reset mid-frame: assert axi_reset after 5 transferred pixels, then send 8 pixels 0x10..0x17.
  - All outputs read 0 during reset.
  - TLAST on 0x17; o_frame_count=1.
- TUSER_SOF_EN: with the streaming stimulus, o_data_user=1 exactly on 0x00 and 0x08.

Source files
------------

// File: rtl/axis_frame_packer.sv
// Pixel stream to AXI-Stream framer: FWFT FIFO, TLAST per IMG_WIDTH*IMG_HEIGHT frame, frame/overflow status.
// Optional `TUSER_SOF_EN adds o_data_user (start-of-frame on pixel 0).
module axis_frame_packer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_data_ready,
  output logic                  o_data_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_last,
  input  logic                  i_data_ready,
  output logic                  o_frame_done,
  output logic [15:0]           o_frame_count,
  output logic                  o_overflow
`ifdef TUSER_SOF_EN
  ,
  output logic                  o_data_user
`endif
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW        = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIX - 1);

  typedef enum logic {S_STREAM, S_DONE} state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  full, empty, wr_en, rd_en, beat_last;
  logic [CW-1:0]         pix_cnt;
  state_t                state, state_nxt;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_en     = ~empty & i_data_ready;
  assign wr_en     = i_data_valid & (~full | rd_en);
  assign beat_last = (pix_cnt == LAST_IDX);

  assign o_data_valid = ~empty;
  assign o_data       = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign o_data_last  = o_data_valid & beat_last;
  assign o_data_ready = ~full & ~axi_reset;
  assign o_frame_done = (state == S_DONE);

`ifdef TUSER_SOF_EN
  assign o_data_user = o_data_valid & (pix_cnt == '0);
`endif

  always_ff @(posedge axi_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pix_cnt       <= '0;
      o_frame_count <= '0;
      o_overflow    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (beat_last) begin
          pix_cnt       <= '0;
          o_frame_count <= o_frame_count + 16'd1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
      if (i_data_valid & ~wr_en) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) state <= S_STREAM;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_STREAM;
    case (state)
      S_STREAM: if (rd_en & beat_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_STREAM;
      default:  state_nxt = S_STREAM;
    endcase
  end

endmodule

// File: tb/tb_axis_frame_packer.sv
// Bench for axis_frame_packer with a 4x2 frame and 4-entry FIFO.
module tb_axis_frame_packer;

  localparam int W = 4, H = 2, DEPTH = 4, FRAME = W * H;

  logic        clk = 1'b0;
  logic        axi_reset = 1'b1;
  logic        i_data_valid = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_data_ready = 1'b0;
  logic        o_data_ready, o_data_valid, o_data_last, o_frame_done, o_overflow;
  logic [7:0]  o_data;
  logic [15:0] o_frame_count;
`ifdef TUSER_SOF_EN
  logic        o_data_user;
`endif

  always #5 clk = ~clk;

  axis_frame_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .axi_clk(clk), .axi_reset(axi_reset),
    .i_data_valid(i_data_valid), .i_data(i_data), .o_data_ready(o_data_ready),
    .o_data_valid(o_data_valid), .o_data(o_data), .o_data_last(o_data_last),
    .i_data_ready(i_data_ready), .o_frame_done(o_frame_done),
    .o_frame_count(o_frame_count), .o_overflow(o_overflow)
`ifdef TUSER_SOF_EN
    , .o_data_user(o_data_user)
`endif
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending pixels plus frame bookkeeping.
  bit   model_on = 0;
  int   mq[$];
  int   m_beats, m_frames;
  bit   m_ovf, m_done;

  // Observed transfers.
  logic [7:0] cap_dat[$];
  bit         cap_last[$];
  bit         cap_user[$];
  int         done_seen;

  task automatic model_reset();
    mq.delete();
    m_beats = 0; m_frames = 0; m_ovf = 0; m_done = 0;
  endtask

  task automatic clear_cap();
    cap_dat.delete(); cap_last.delete(); cap_user.delete(); done_seen = 0;
  endtask

  // Called at a falling edge: drive inputs, observe, then advance one clock.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    bit pop;
    i_data_valid = v; i_data = d; i_data_ready = r;
    #1;
    if (o_data_valid && r) begin
      cap_dat.push_back(o_data);
      cap_last.push_back(o_data_last);
`ifdef TUSER_SOF_EN
      cap_user.push_back(o_data_user);
`else
      cap_user.push_back(1'b0);
`endif
    end
    if (o_frame_done) done_seen++;
    if (model_on) begin
      chk("m_vld", o_data_valid, mq.size() > 0);
      if (mq.size() > 0) chk("m_dat", o_data, mq[0]);
      chk("m_last", o_data_last, (mq.size() > 0) && (m_beats == FRAME - 1));
      chk("m_rdy", o_data_ready, mq.size() < DEPTH);
      chk("m_done", o_frame_done, m_done);
      chk("m_fcnt", o_frame_count, m_frames);
      chk("m_ovf", o_overflow, m_ovf);
`ifdef TUSER_SOF_EN
      chk("m_user", o_data_user, (mq.size() > 0) && (m_beats == 0));
`endif
      m_done = 0;
      pop = (mq.size() > 0) && r;
      if (pop) begin
        void'(mq.pop_front());
        if (m_beats == FRAME - 1) begin
          m_beats = 0; m_frames = (m_frames + 1) % 65536; m_done = 1;
        end else m_beats++;
      end
      if (v) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1;
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_vld", o_data_valid, 0);
    chk("rst_dat", o_data, 0);
    chk("rst_last", o_data_last, 0);
    chk("rst_done", o_frame_done, 0);
    chk("rst_fcnt", o_frame_count, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_rdy", o_data_ready, 0);
`ifdef TUSER_SOF_EN
    chk("rst_user", o_data_user, 0);
`endif
  endtask

  task automatic do_reset();
    axi_reset = 1'b1;
    i_data_valid = 1'b0; i_data = 8'h00; i_data_ready = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); @(negedge clk);
    check_reset_outputs();
    axi_reset = 1'b0;
    #1;
    chk("post_rst_rdy", o_data_ready, 1);
    chk("post_rst_vld", o_data_valid, 0);
    model_reset();
  endtask

  typedef struct {
    logic v; logic [7:0] d; logic r;
    logic e_vld; logic [7:0] e_dat; logic e_last; logic e_rdy; logic e_ovf; logic e_done;
    logic [15:0] e_fc;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic ev, logic [7:0] ed,
                              logic el, logic er, logic eo, logic edn, logic [15:0] ef);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.e_vld = ev; t.e_dat = ed; t.e_last = el;
    t.e_rdy = er; t.e_ovf = eo; t.e_done = edn; t.e_fc = ef;
    return t;
  endfunction

  vec_t tbl[16];

  initial begin
    logic [7:0] exp_seq[8];
    // Fill with backpressure, stream through a full FIFO, drop 0xFF, then drain to TLAST.
    tbl[0]  = mk(1, 8'hA0, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    tbl[1]  = mk(1, 8'hA1, 0, 1, 8'hA0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 8'hA2, 0, 1, 8'hA0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 8'hA3, 0, 1, 8'hA0, 0, 1, 0, 0, 0);
    tbl[4]  = mk(1, 8'hA4, 1, 1, 8'hA0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 8'hA5, 1, 1, 8'hA1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 8'hA6, 1, 1, 8'hA2, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 8'hA7, 1, 1, 8'hA3, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 8'hFF, 0, 1, 8'hA4, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 8'h00, 0, 1, 8'hA4, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 8'h00, 1, 1, 8'hA4, 0, 0, 1, 0, 0);
    tbl[11] = mk(0, 8'h00, 1, 1, 8'hA5, 0, 1, 1, 0, 0);
    tbl[12] = mk(0, 8'h00, 1, 1, 8'hA6, 0, 1, 1, 0, 0);
    tbl[13] = mk(0, 8'h00, 1, 1, 8'hA7, 1, 1, 1, 0, 0);
    tbl[14] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 1, 1);
    tbl[15] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 1);

    #1;
    check_reset_outputs();
    @(negedge clk);
    do_reset();

    // Streaming: 16 pixels back to back with the sink always ready.
    clear_cap();
    for (int i = 0; i < 18; i++) begin
      step(i < 16, 8'(i), 1'b1);
      if (i == 0) begin
        chk("lat_vld", o_data_valid, 1);
        chk("lat_dat", o_data, 0);
      end
    end
    chk("str_cnt", cap_dat.size(), 16);
    for (int i = 0; i < cap_dat.size(); i++) begin
      chk($sformatf("str_dat%0d", i), cap_dat[i], i);
      chk($sformatf("str_last%0d", i), cap_last[i], (i == 7) || (i == 15));
`ifdef TUSER_SOF_EN
      chk($sformatf("str_user%0d", i), cap_user[i], (i == 0) || (i == 8));
`endif
    end
    chk("str_done", done_seen, 2);
    chk("str_fcnt", o_frame_count, 2);
    chk("str_ovf", o_overflow, 0);

    // Table: backpressure, full read/write, overflow drop, TLAST placement.
    do_reset();
    clear_cap();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tbl%0d_vld", i), o_data_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_dat", i), o_data, tbl[i].e_dat);
      chk($sformatf("tbl%0d_last", i), o_data_last, tbl[i].e_last);
      chk($sformatf("tbl%0d_rdy", i), o_data_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_ovf", i), o_overflow, tbl[i].e_ovf);
      chk($sformatf("tbl%0d_done", i), o_frame_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_fcnt", i), o_frame_count, tbl[i].e_fc);
      step(tbl[i].v, tbl[i].d, tbl[i].r);
    end
    exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    chk("tbl_cap_cnt", cap_dat.size(), 8);
    for (int i = 0; i < cap_dat.size() && i < 8; i++)
      chk($sformatf("tbl_cap%0d", i), cap_dat[i], exp_seq[i]);

    // Reset mid-frame: 5 pixels transferred, one still queued, then reset.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'h20 + 8'(i), 1'b1);
    chk("mid_vld_before", o_data_valid, 1);
    do_reset();
    clear_cap();
    for (int i = 0; i < 10; i++) step(i < 8, 8'h10 + 8'(i), 1'b1);
    chk("mid_cnt", cap_dat.size(), 8);
    for (int i = 0; i < cap_dat.size(); i++) begin
      chk($sformatf("mid_dat%0d", i), cap_dat[i], 8'h10 + i);
      chk($sformatf("mid_last%0d", i), cap_last[i], i == 7);
    end
    chk("mid_fcnt", o_frame_count, 1);

    // Randomized traffic against the reference model.
    do_reset();
    model_on = 1;
    for (int blk = 0; blk < 30; blk++) begin
      int pv = $urandom_range(20, 100);
      int pr = $urandom_range(10, 100);
      for (int i = 0; i < 100; i++)
        step($urandom_range(1, 100) <= pv, 8'($urandom), $urandom_range(1, 100) <= pr);
    end
    // Drain and confirm the queue empties.
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    model_on = 0;
    chk("rnd_empty", o_data_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
